// File: rtl/pilot_carrier_38khz_pkg.sv
// Shared definitions for pilot_carrier_38khz: FSM state encoding, default
// tuning constants and the 16-bit saturation helper.
package pilot_carrier_38khz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        DC,
        ENV,
        OUT
    } state_e;

    localparam int          DEF_DC_SHIFT   = 8;
    localparam logic [15:0] DEF_LOCK_ON    = 16'd64;
    localparam logic [15:0] DEF_LOCK_OFF   = 16'd32;
    localparam int          DEF_LOCK_COUNT = 4096;
    localparam int          LOCK_CNT_W     = 13;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sd32767;
        end else if (v < -18'sd32768) begin
            return -16'sd32768;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/pilot_carrier_38khz_if.sv
// Sample-stream bundle between the pilot bandpass, this block and its consumers.
interface pilot_carrier_38khz_if;
    logic signed [15:0] xin;
    logic               in_tick;
    logic signed [15:0] carrier;
    logic        [15:0] pilot_level;
    logic               stereo_lock;
    logic               out_tick;

    modport master (
        output xin, in_tick,
        input  carrier, pilot_level, stereo_lock, out_tick
    );

    modport slave (
        input  xin, in_tick,
        output carrier, pilot_level, stereo_lock, out_tick
    );
endinterface

// File: rtl/pilot_carrier_38khz_lock_hysteresis.sv
// Hysteretic presence detector: the flag toggles after COUNT consecutive
// qualifying levels (>= ON_TH to acquire, < OFF_TH to release).
module pilot_carrier_38khz_lock_hysteresis #(
    parameter int                 LEVEL_W = 16,
    parameter logic [LEVEL_W-1:0] ON_TH   = LEVEL_W'(64),
    parameter logic [LEVEL_W-1:0] OFF_TH  = LEVEL_W'(32),
    parameter int                 COUNT   = 4096,
    parameter int                 CNT_W   = 13
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               sample_valid,
    input  logic [LEVEL_W-1:0] level,
    output logic               lock
);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(COUNT);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             lock_q, lock_d;
    logic             qualify;

    always_comb begin
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        qualify = lock_q ? (level < OFF_TH) : (level >= ON_TH);
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (sample_valid) begin
            if (!qualify) begin
                cnt_d = '0;
            end else if (cnt_inc == CNT_TGT) begin
                lock_d = ~lock_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign lock = lock_q;

endmodule

// File: rtl/pilot_carrier_38khz.sv
// Squares the bandpassed 19 kHz pilot into a DC-blocked 38 kHz carrier and
// tracks pilot power for stereo lock. Build option: PILOT_CARRIER_MUTE_EN.
module pilot_carrier_38khz
    import pilot_carrier_38khz_pkg::*;
#(
    parameter int          DC_SHIFT   = DEF_DC_SHIFT,
    parameter logic [15:0] LOCK_ON    = DEF_LOCK_ON,
    parameter logic [15:0] LOCK_OFF   = DEF_LOCK_OFF,
    parameter int          LOCK_COUNT = DEF_LOCK_COUNT
) (
    input logic                  CLK,
    input logic                  RST,
    pilot_carrier_38khz_if.slave bus
);
    localparam int ACC_W = 16 + DC_SHIFT;

    state_e             state_q, state_d;
    logic signed [15:0] x_q, x_d;
    logic        [14:0] sq16_q, sq16_d;
    logic   [ACC_W-1:0] dc_acc_q, dc_acc_d;
    logic        [15:0] dc_q, dc_d;
    logic signed [15:0] carr_next_q, carr_next_d;
    logic signed [15:0] carrier_q, carrier_d;
    logic        [15:0] pilot_level_q, pilot_level_d;
    logic               stereo_lock_q, stereo_lock_d;
    logic               out_tick_q, out_tick_d;

    logic signed [31:0] sq;
    logic        [16:0] sq_hi;
    logic        [14:0] sq16_calc;
    logic   [ACC_W-1:0] acc_sum;
    logic        [15:0] dc_calc;
    logic signed [17:0] carr_raw;
    logic               lock_strobe;
    logic               lock_flag;

    // The squared pilot is never negative, so the shifted product is an unsigned magnitude.
    assign sq        = x_q * x_q;
    assign sq_hi     = 17'(sq >>> 15);
    assign sq16_calc = (sq_hi > 17'd32767) ? 15'h7fff : sq_hi[14:0];
    assign acc_sum   = dc_acc_q + ACC_W'(sq16_q) - (dc_acc_q >> DC_SHIFT);
    assign dc_calc   = 16'(acc_sum >> DC_SHIFT);
    assign carr_raw  = ($signed({3'b000, sq16_q}) - $signed({2'b00, dc_q})) <<< 1;

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through the case infers a latch.
        state_d       = state_q;
        x_d           = x_q;
        sq16_d        = sq16_q;
        dc_acc_d      = dc_acc_q;
        dc_d          = dc_q;
        carr_next_d   = carr_next_q;
        carrier_d     = carrier_q;
        pilot_level_d = pilot_level_q;
        stereo_lock_d = stereo_lock_q;
        out_tick_d    = 1'b0;
        lock_strobe   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_tick) begin
                    x_d     = bus.xin;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                sq16_d  = sq16_calc;
                state_d = DC;
            end
            DC: begin
                dc_acc_d = acc_sum;
                dc_d     = dc_calc;
                state_d  = ENV;
            end
            ENV: begin
                carr_next_d = sat16(carr_raw);
                lock_strobe = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                // lock_flag already reflects this sample's update here.
`ifdef PILOT_CARRIER_MUTE_EN
                carrier_d = lock_flag ? carr_next_q : 16'sd0;
`else
                carrier_d = carr_next_q;
`endif
                pilot_level_d = dc_q;
                stereo_lock_d = lock_flag;
                out_tick_d    = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and wins over in_tick, so a strobe during RST is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            x_q           <= '0;
            sq16_q        <= '0;
            dc_acc_q      <= '0;
            dc_q          <= '0;
            carr_next_q   <= '0;
            carrier_q     <= '0;
            pilot_level_q <= '0;
            stereo_lock_q <= 1'b0;
            out_tick_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            sq16_q        <= sq16_d;
            dc_acc_q      <= dc_acc_d;
            dc_q          <= dc_d;
            carr_next_q   <= carr_next_d;
            carrier_q     <= carrier_d;
            pilot_level_q <= pilot_level_d;
            stereo_lock_q <= stereo_lock_d;
            out_tick_q    <= out_tick_d;
        end
    end

    pilot_carrier_38khz_lock_hysteresis #(
        .LEVEL_W (16),
        .ON_TH   (LOCK_ON),
        .OFF_TH  (LOCK_OFF),
        .COUNT   (LOCK_COUNT),
        .CNT_W   (LOCK_CNT_W)
    ) u_lock (
        .CLK          (CLK),
        .RST          (RST),
        .sample_valid (lock_strobe),
        .level        (dc_q),
        .lock         (lock_flag)
    );

    assign bus.carrier     = carrier_q;
    assign bus.pilot_level = pilot_level_q;
    assign bus.stereo_lock = stereo_lock_q;
    assign bus.out_tick    = out_tick_q;

endmodule
